// File: rtl/apex_axil_regbank.sv
// AXI4-Lite register bank: RW/RO registers, per-register write strobes, self-clearing START bit.
// Optional macro APEX_AXIL_SLVERR_EN returns SLVERR for RO / out-of-range accesses.
module apex_axil_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 7,
  parameter int          NUM_REGS           = 8,
  parameter logic [31:0] RO_MASK            = 32'h0000_0020
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]                    o_wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] i_ro_data
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(DW/8);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W:0] NUM_REGS_W = NUM_REGS[IDX_W:0];

`ifdef APEX_AXIL_SLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic [AW-1:0]  upper;
    logic [IDX_W:0] idx;
    upper   = a >> (ADDR_LSB + IDX_W);
    idx     = {1'b0, a[ADDR_LSB +: IDX_W]};
    addr_ok = (upper == {AW{1'b0}}) && (idx < NUM_REGS_W);
  endfunction

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    for (int b = 0; b < DW/8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DW-1:0]       regs_r [NUM_REGS];
  logic                aw_held_r, w_held_r, aw_ok_r;
  logic [IDX_W-1:0]    aw_idx_r;
  logic [DW-1:0]       w_data_r;
  logic [DW/8-1:0]     w_strb_r;
  logic                awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]          bresp_r, rresp_r;
  logic [DW-1:0]       rdata_r;
  logic [NUM_REGS-1:0] wr_pulse_r;

  logic                aw_hs_s, w_hs_s, ar_hs_s, wr_commit_s, wr_ok_s;
  logic                aw_held_nx_s, w_held_nx_s, bvalid_nx_s, rvalid_nx_s;
  logic [DW-1:0]       wr_base_s, wr_val_s, rd_val_s;
  logic [NUM_REGS-1:0] wr_sel_s;
  logic                ar_ok_s;
  logic [IDX_W-1:0]    ar_idx_s;
  logic                unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Handshakes, commit decode and next-state of the channel flags
  always_comb begin
    aw_hs_s     = S_AXI_AWVALID && awready_r;
    w_hs_s      = S_AXI_WVALID && wready_r;
    ar_hs_s     = S_AXI_ARVALID && arready_r;
    wr_commit_s = aw_held_r && w_held_r && !bvalid_r;
    wr_ok_s     = aw_ok_r && !RO_MASK[aw_idx_r];
    wr_base_s   = aw_ok_r ? regs_r[aw_idx_r] : {DW{1'b0}};
    // START never survives into a later write's merge
    if (aw_idx_r == {IDX_W{1'b0}}) begin
      wr_base_s[0] = 1'b0;
    end else begin
      wr_base_s[0] = wr_base_s[0];
    end
    wr_val_s     = apply_strb(wr_base_s, w_data_r, w_strb_r);
    aw_held_nx_s = (aw_held_r || aw_hs_s) && !wr_commit_s;
    w_held_nx_s  = (w_held_r || w_hs_s) && !wr_commit_s;
    bvalid_nx_s  = wr_commit_s || (bvalid_r && !S_AXI_BREADY);
    rvalid_nx_s  = ar_hs_s || (rvalid_r && !S_AXI_RREADY);
    ar_ok_s      = addr_ok(S_AXI_ARADDR);
    ar_idx_s     = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    rd_val_s     = ar_ok_s ? regs_r[ar_idx_s] : {DW{1'b0}};
    for (int n = 0; n < NUM_REGS; n++) begin
      wr_sel_s[n] = wr_commit_s && wr_ok_s && (aw_idx_r == IDX_W'(n));
    end
  end

  // Write address/data capture, B channel and write-side readies
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_ok_r    <= 1'b0;
      aw_idx_r   <= {IDX_W{1'b0}};
      w_data_r   <= {DW{1'b0}};
      w_strb_r   <= {(DW/8){1'b0}};
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      wr_pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_ok_r  <= addr_ok(S_AXI_AWADDR);
        aw_idx_r <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
      end else begin
        aw_ok_r  <= aw_ok_r;
        aw_idx_r <= aw_idx_r;
      end
      if (w_hs_s) begin
        w_data_r <= S_AXI_WDATA;
        w_strb_r <= S_AXI_WSTRB;
      end else begin
        w_data_r <= w_data_r;
        w_strb_r <= w_strb_r;
      end
      if (wr_commit_s) begin
        bresp_r <= (ERR_EN && !wr_ok_s) ? 2'b10 : 2'b00;
      end else begin
        bresp_r <= bresp_r;
      end
      aw_held_r  <= aw_held_nx_s;
      w_held_r   <= w_held_nx_s;
      bvalid_r   <= bvalid_nx_s;
      awready_r  <= !aw_held_nx_s && !bvalid_nx_s;
      wready_r   <= !w_held_nx_s && !bvalid_nx_s;
      wr_pulse_r <= wr_sel_s;
    end
  end

  // Register array: RO follow i_ro_data, RW take committed writes, START self-clears
  always_ff @(posedge S_AXI_ACLK) begin
    for (int n = 0; n < NUM_REGS; n++) begin
      if (RO_MASK[n]) begin
        regs_r[n] <= i_ro_data[n*DW +: DW];
      end else if (!S_AXI_ARESETN) begin
        regs_r[n] <= {DW{1'b0}};
      end else if (wr_sel_s[n]) begin
        regs_r[n] <= wr_val_s;
      end else if (n == 0) begin
        regs_r[n] <= {regs_r[n][DW-1:1], 1'b0};
      end else begin
        regs_r[n] <= regs_r[n];
      end
    end
  end

  // Read channel; data sampled at the AR handshake sees the pre-write value
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      rresp_r   <= 2'b00;
    end else begin
      if (ar_hs_s) begin
        rdata_r <= rd_val_s;
        rresp_r <= (ERR_EN && !ar_ok_s) ? 2'b10 : 2'b00;
      end else begin
        rdata_r <= rdata_r;
        rresp_r <= rresp_r;
      end
      rvalid_r  <= rvalid_nx_s;
      arready_r <= !rvalid_nx_s;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_regs[g*DW +: DW] = regs_r[g];
    end
  endgenerate

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign o_wr_pulse    = wr_pulse_r;

endmodule

// File: doc/apex_axil_regbank.md
APEX_AXIL_REGBANK -- requirements
Module: apex_axil_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (32 or 64 only).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, AXI byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count, 2..32, with NUM_REGS*(C_S_AXI_DATA_WIDTH/8) <= 2**C_S_AXI_ADDR_WIDTH.
REQ-004 SHALL have parameter RO_MASK, default 32'h0000_0020, bit n set makes register n read-only (hardware-driven).
REQ-005 SHALL have ports S_AXI_ACLK in 1 clock and S_AXI_ARESETN in 1; one clock, reset synchronous and active-low.
REQ-006 SHALL have AXI4-Lite slave ports S_AXI_AW{ADDR,PROT,VALID,READY}, S_AXI_W{DATA,STRB,VALID,READY}, S_AXI_B{RESP,VALID,READY}, S_AXI_AR{ADDR,PROT,VALID,READY} and S_AXI_R{DATA,RESP,VALID,READY}, with standard directions and widths.
REQ-007 SHALL have o_regs out NUM_REGS*C_S_AXI_DATA_WIDTH, flattened register contents, register n at slice n.
REQ-008 SHALL have o_wr_pulse out NUM_REGS, one-cycle strobe per register on each committed write.
REQ-009 SHALL have i_ro_data in NUM_REGS*C_S_AXI_DATA_WIDTH, values sampled into RO registers.

Function
REQ-010 SHALL decode register index as addr[ADDR_LSB +: clog2(NUM_REGS)], with ADDR_LSB = clog2(C_S_AXI_DATA_WIDTH/8), and treat index >= NUM_REGS or nonzero upper address bits as out of range.
REQ-011 SHALL accept AW and W independently: AWREADY high when no AW is held and no B is pending; WREADY high when no W is held and no B is pending; either order or the same cycle.
REQ-012 SHALL commit a write in the cycle after both AW and W are held (or captured together), apply WSTRB per byte, assert BVALID the same cycle, and hold BVALID and BRESP until BREADY.
REQ-013 SHALL allow only one write outstanding: no new AW or W accepted while BVALID is high; AWREADY and WREADY return high in the cycle after the B handshake.
REQ-014 SHALL ignore writes to RO or out-of-range registers, with no o_wr_pulse and BRESP OKAY (see REQ-024).
REQ-015 SHALL load each RO register from i_ro_data every cycle.
REQ-016 SHALL make register 0 bit 0 (START) self-clearing: set by a write of 1, cleared automatically one cycle later.
REQ-017 SHALL hold ARREADY high while RVALID is low, register RDATA and RRESP on the AR handshake, assert RVALID the next cycle, and hold both until RREADY.
REQ-018 SHALL return 0 as RDATA for out-of-range reads.
REQ-019 SHALL, when a read and a write commit to the same register in the same cycle, return the pre-write value on the read.
REQ-020 SHALL ignore AWPROT and ARPROT.

Reset
REQ-021 SHALL, while S_AXI_ARESETN=0 at a clock edge, clear all RW registers, held AW/W state, AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP and o_wr_pulse.
REQ-022 SHALL raise AWREADY, WREADY and ARREADY in the first cycle after reset release.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation with no register update.

Configuration
REQ-024 SHALL, when macro APEX_AXIL_SLVERR_EN is defined, return SLVERR (2'b10) on BRESP for RO or out-of-range writes and on RRESP for out-of-range reads; without the macro all responses SHALL be OKAY.

Verification
REQ-025 SHALL cover: AW at 0x08 with W 0xA5A5_0001 and WSTRB 4'hF in the same cycle -> BVALID, o_regs[2]=0xA5A5_0001 and o_wr_pulse[2] one cycle.
REQ-026 SHALL cover: W 0x1234_5678 with WSTRB 4'h3, then AW 0x0C three cycles later, on a register preset to 0xFFFF_FFFF -> register 3 reads 0xFFFF_5678 and exactly one B.
REQ-027 SHALL cover: write 0x1 to 0x00 -> START high for exactly one cycle, then reads back 0.
REQ-028 SHALL cover: write to 0x14 (RO) with i_ro_data slice 5 = 0xCAFE -> read 0x14 returns 0xCAFE and BRESP is OKAY (SLVERR with macro).
REQ-029 SHALL cover: read 0x7C with RREADY held low 5 cycles -> RVALID and RDATA=0 stable, ARREADY low, RRESP OKAY (SLVERR with macro).
REQ-030 SHALL cover: reset asserted with AW held and W pending -> after release, no register changed and BVALID=0.
